bitg: RTL and testbench
=======================

BITG -- requirements
Module: bitg

Interface
REQ-001 Parameter WIDTH, default 1, width of the stored word; all tests use WIDTH=1.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in  input  WIDTH  data to be stored.
REQ-005 load  input  1  write enable; when 1, in is captured at the next rising clk edge.
REQ-006 out  output  WIDTH  stored value, driven directly from the storage flop (registered output).
REQ-007 Positional port order SHALL be in, load, clk, out, rst, so existing four-port positional instantiations remain valid; rst SHALL be left unconnected in those instantiations.
REQ-008 The block SHALL use one clock (clk) and one synchronous, active-high reset (rst); no other clocks or asynchronous inputs.

Function
REQ-009 On a rising clk edge with rst=0 and load=1, out SHALL take the value of in sampled at that edge.
REQ-010 On a rising clk edge with rst=0 and load=0, out SHALL hold its previous value.
REQ-011 Latency SHALL be exactly one clock edge from load/in being sampled to out changing; no combinational path from in or load to out.
REQ-012 out SHALL NOT change on the falling clk edge, nor when in or load change between rising edges.
REQ-013 Changes to in or load made in the same time step as the rising edge, but scheduled after it (nonblocking), SHALL NOT affect the value captured at that edge.
REQ-014 With WIDTH>1, all bits SHALL be loaded or held together under the single load signal.
REQ-015 The stored value SHALL initialise to 0 at time zero, so out is 0 before any reset or load.

Reset
REQ-016 On a rising clk edge with rst=1, out SHALL become 0, regardless of load and in.
REQ-017 Reset SHALL take priority over load on the same edge.
REQ-018 Asserting rst between clock edges SHALL have no effect until the next rising edge.
REQ-019 Load behaviour SHALL resume on the first rising edge at which rst=0.
REQ-020 If rst is left unconnected, it SHALL be treated as deasserted.

Structure
REQ-021 No shared package is needed; WIDTH is the only constant and is a module parameter.
REQ-022 Storage SHALL be one sub-module, dff: a WIDTH-wide rising-edge D flip-flop with synchronous reset.
REQ-023 A 2:1 select (load ? in : out) SHALL feed the dff D input.
REQ-024 The block SHALL contain no latches and no other state.

Verification
REQ-025 Load 0: in=0, load=1, rising edge -> out=0; then falling edge -> out=0.
REQ-026 Hold: rising edge with load=0 -> out stays 0.
REQ-027 Load 1: in=1, load=1, rising edge -> out=1; before that edge (clk low) -> out=0.
REQ-028 Hold 1: load=0, in=0, rising edge -> out=1; following falling edge -> out=1.
REQ-029 Reset priority: out=1, then rst=1, load=1, in=1, rising edge -> out=0; then rst=0 with load=0 -> out stays 0.
REQ-030 Mid-cycle change: out=1, load=1 and in=0 applied while clk is low -> out stays 1 until the next rising edge, then out=0.

Source files
------------

// File: rtl/bitg_dff.sv
// dff -- WIDTH-wide rising-edge D flip-flop with synchronous, active-high reset.
//   clk : clock, captures on rising edge
//   rst : synchronous reset, forces q to 0 and wins over d
//   d   : next value
//   q   : stored value, straight from the flop
module dff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Initialiser gives a defined 0 from time zero, before any reset edge.
  logic [WIDTH-1:0] q_q = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bitg.sv
// bitg -- WIDTH-bit storage register with load enable.
//   in   : data to store
//   load : write enable; in is captured on the next rising clk edge when 1
//   clk  : single clock
//   out  : stored value, driven directly from the storage flop
//   rst  : synchronous, active-high reset (clears out, priority over load)
// Port order is kept as in, load, clk, out, rst so legacy four-port
// positional instantiations still bind.
module bitg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             clk,
  output logic [WIDTH-1:0] out,
  input  logic             rst
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Hold is done by recirculating the flop output, so the flop itself
  // stays a plain D flop and all bits share one load decision.
  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = in;
    end
  end

  dff #(.WIDTH(WIDTH)) u_dff (
    .clk (clk),
    .rst (rst),
    .d   (out_d),
    .q   (out_q)
  );

  assign out = out_q;

endmodule

// File: tb/tb_bitg.sv
module tb_bitg;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       load = 1'b0;
  logic [0:0] in   = '0;
  logic [0:0] out;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  typedef struct {
    string      name;
    logic [0:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;

  bitg #(.WIDTH(1)) dut (
    .in   (in),
    .load (load),
    .clk  (clk),
    .out  (out),
    .rst  (rst)
  );

  always #5 clk = ~clk;

  // Stimulus side: record the expected value and request a sample.
  task automatic expect_out(input string name, input logic [0:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    -> sample_ev;
  endtask

  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations and compares against the live output.
  initial begin
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_total++;
        if (out === e.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: out=%b expected=%b at t=%0t", e.name, out, e.exp, $time);
        end
      end
    end
  end

  initial begin
    // Power-up value before any edge.
    #1;
    expect_out("init_zero", 1'b0);

    @(negedge clk); rst = 1'b1;
    after_rise();
    expect_out("reset_zero", 1'b0);
    @(negedge clk); rst = 1'b0;

    // Load 0, then falling edge.
    in = 1'b0; load = 1'b1;
    after_rise();
    expect_out("load0_rise", 1'b0);
    @(negedge clk); #1;
    expect_out("load0_fall", 1'b0);

    // Hold 0.
    load = 1'b0;
    after_rise();
    expect_out("hold0", 1'b0);

    // Load 1; still 0 while clk low before the edge.
    @(negedge clk); in = 1'b1; load = 1'b1;
    #4;
    expect_out("load1_pre_edge", 1'b0);
    after_rise();
    expect_out("load1_rise", 1'b1);

    // Hold 1 with in=0.
    @(negedge clk); load = 1'b0; in = 1'b0;
    after_rise();
    expect_out("hold1_rise", 1'b1);
    @(negedge clk); #1;
    expect_out("hold1_fall", 1'b1);

    // in toggling between edges with load=0 must not disturb out.
    in = 1'b0; #1; in = 1'b1; #1;
    expect_out("in_toggle_noload", 1'b1);
    after_rise();
    expect_out("in_toggle_edge", 1'b1);

    // Reset priority over load; mid-cycle rst has no effect until the edge.
    @(negedge clk); rst = 1'b1; load = 1'b1; in = 1'b1;
    #1;
    expect_out("rst_midcycle", 1'b1);
    after_rise();
    expect_out("rst_priority", 1'b0);
    @(negedge clk); rst = 1'b0; load = 1'b0;
    after_rise();
    expect_out("post_rst_hold", 1'b0);

    // Load resumes after reset released.
    @(negedge clk); load = 1'b1; in = 1'b1;
    after_rise();
    expect_out("load_resume", 1'b1);

    // Mid-cycle change of load/in while clk low.
    @(negedge clk); load = 1'b1; in = 1'b0;
    #1;
    expect_out("midcycle_hold_a", 1'b1);
    #2;
    expect_out("midcycle_hold_b", 1'b1);
    after_rise();
    expect_out("midcycle_edge", 1'b0);

    #20;
    // Any expectation the monitor never consumed is a failure.
    n_total++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
